frog_hop_ctrl: RTL and testbench

Converts the four raw direction keys into clean, frame-aligned hop commands for the frog position stage. Each key is synchronised and debounced, and a new press is latched and launched on the next frame tick. The matching direction output is then held for exactly `HOP_FRAMES` frame ticks, followed by a cooldown. Outputs drive the position stage's `left`/`right`/`up`/`down` inputs, which sample on the same frame tick.

---
 rtl/frog_hop_if.sv | 27 ++
 rtl/frog_hop_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_frog_hop_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frog_hop_if.sv
// frog_hop_if: key inputs, frame strobes and hop command outputs of frog_hop_ctrl.
// The master side drives keys/strobes; the slave side is the controller.
interface frog_hop_if;
    logic       frame_tick;
    logic       freeze;
    logic       key_left;
    logic       key_right;
    logic       key_up;
    logic       key_down;
    logic       left;
    logic       right;
    logic       up;
    logic       down;
    logic       hop_active;
    logic       hop_done;
    logic [7:0] up_hops;

    modport master (
        output frame_tick, freeze, key_left, key_right, key_up, key_down,
        input  left, right, up, down, hop_active, hop_done, up_hops
    );

    modport slave (
        input  frame_tick, freeze, key_left, key_right, key_up, key_down,
        output left, right, up, down, hop_active, hop_done, up_hops
    );
endinterface

// File: rtl/frog_hop_ctrl.sv
// frog_hop_ctrl: debounces four direction keys and issues frame-aligned hop commands.
// Define FROG_AUTOREPEAT_EN to re-arm a hop from still-held keys when returning to IDLE.
module frog_hop_ctrl #(
    parameter int HOP_FRAMES      = 8,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic      CLK,
    input  logic      RESETn,
    frog_hop_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOP, COOL} state_t;

    localparam logic [1:0]  DIR_UP    = 2'd0;
    localparam logic [7:0]  HOP_LAST  = 8'(HOP_FRAMES - 1);
    localparam logic [7:0]  COOL_LAST = 8'(COOLDOWN_FRAMES - 1);
    localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);

    // Key vectors are ordered by priority: bit 0 up, 1 down, 2 left, 3 right.
    logic [3:0]  keys_raw;
    logic [3:0]  meta_q, meta_d;
    logic [3:0]  sync_q, sync_d;
    logic [3:0]  stable_q, stable_d;
    logic [3:0]  stable_prev_q, stable_prev_d;
    logic [15:0] db_cnt_q [4];
    logic [15:0] db_cnt_d [4];
    logic [3:0]  press;
    logic [3:0]  repeat_keys;
    logic        enter_idle;

    state_t      state_q, state_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [1:0]  dir_q, dir_d;
    logic        pend_valid_q, pend_valid_d;
    logic [1:0]  pend_dir_q, pend_dir_d;
    logic [3:0]  dirs_q, dirs_d;
    logic        hop_active_q, hop_active_d;
    logic        hop_done_q, hop_done_d;
    logic [7:0]  up_hops_q, up_hops_d;

    function automatic logic [1:0] pick_dir(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign keys_raw = {bus.key_right, bus.key_left, bus.key_down, bus.key_up};
    assign press    = stable_q & ~stable_prev_q;

`ifdef FROG_AUTOREPEAT_EN
    assign repeat_keys = stable_q;
`else
    assign repeat_keys = 4'b0000;
`endif

    // The counter runs only while the synced level disagrees with the accepted one.
    always_comb begin
        meta_d        = keys_raw;
        sync_d        = meta_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        for (int k = 0; k < 4; k++) begin
            db_cnt_d[k] = 16'd0;
            if (sync_q[k] != stable_q[k]) begin
                if (db_cnt_q[k] == DB_LAST) begin
                    stable_d[k] = sync_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        dir_d        = dir_q;
        pend_valid_d = pend_valid_q;
        pend_dir_d   = pend_dir_q;
        hop_done_d   = 1'b0;
        up_hops_d    = up_hops_q;
        enter_idle   = 1'b0;
        if (bus.freeze) begin
            state_d      = IDLE;
            frame_cnt_d  = 8'd0;
            pend_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.frame_tick && pend_valid_q) begin
                        state_d      = HOP;
                        frame_cnt_d  = 8'd0;
                        dir_d        = pend_dir_q;
                        pend_valid_d = 1'b0;
                    end else if ((press != 4'b0000) && !pend_valid_q) begin
                        pend_valid_d = 1'b1;
                        pend_dir_d   = pick_dir(press);
                    end
                end
                HOP: begin
                    if (bus.frame_tick) begin
                        if (frame_cnt_q == HOP_LAST) begin
                            hop_done_d  = 1'b1;
                            frame_cnt_d = 8'd0;
                            if ((dir_q == DIR_UP) && (up_hops_q != 8'hFF)) begin
                                up_hops_d = up_hops_q + 8'd1;
                            end
                            if (COOLDOWN_FRAMES == 0) begin
                                state_d    = IDLE;
                                enter_idle = 1'b1;
                            end else begin
                                state_d = COOL;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                COOL: begin
                    if (bus.frame_tick) begin
                        if (frame_cnt_q == COOL_LAST) begin
                            state_d     = IDLE;
                            frame_cnt_d = 8'd0;
                            enter_idle  = 1'b1;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            // Held keys re-arm only on a natural return to IDLE, never after freeze.
            if (enter_idle && (repeat_keys != 4'b0000)) begin
                pend_valid_d = 1'b1;
                pend_dir_d   = pick_dir(repeat_keys);
            end
        end
        dirs_d = 4'b0000;
        if (state_d == HOP) begin
            dirs_d[dir_d] = 1'b1;
        end
        hop_active_d = (state_d == HOP);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            meta_q        <= 4'b0000;
            sync_q        <= 4'b0000;
            stable_q      <= 4'b0000;
            stable_prev_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                db_cnt_q[k] <= 16'd0;
            end
            state_q      <= IDLE;
            frame_cnt_q  <= 8'd0;
            dir_q        <= 2'd0;
            pend_valid_q <= 1'b0;
            pend_dir_q   <= 2'd0;
            dirs_q       <= 4'b0000;
            hop_active_q <= 1'b0;
            hop_done_q   <= 1'b0;
            up_hops_q    <= 8'd0;
        end else begin
            meta_q        <= meta_d;
            sync_q        <= sync_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            for (int k = 0; k < 4; k++) begin
                db_cnt_q[k] <= db_cnt_d[k];
            end
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            dir_q        <= dir_d;
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
            dirs_q       <= dirs_d;
            hop_active_q <= hop_active_d;
            hop_done_q   <= hop_done_d;
            up_hops_q    <= up_hops_d;
        end
    end

    assign bus.up         = dirs_q[0];
    assign bus.down       = dirs_q[1];
    assign bus.left       = dirs_q[2];
    assign bus.right      = dirs_q[3];
    assign bus.hop_active = hop_active_q;
    assign bus.hop_done   = hop_done_q;
    assign bus.up_hops    = up_hops_q;
endmodule

// File: tb/tb_frog_hop_ctrl.sv
// tb_frog_hop_ctrl: scenario tasks plus randomized keys, checked against a tick-level model.
// The model follows FROG_AUTOREPEAT_EN the same way the design build does.
module tb_frog_hop_ctrl;
    localparam int HF = 8;
    localparam int CF = 4;
    localparam int DB = 16;

    logic CLK;
    logic RESETn;
    int   n_checks;
    int   n_pass;
    int   tick_period;

    frog_hop_if bus ();

    frog_hop_ctrl #(
        .HOP_FRAMES      (HF),
        .COOLDOWN_FRAMES (CF),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Frame strobe generator; period can be changed by the scenario tasks.
    initial begin
        int tcount;
        tcount = 0;
        bus.frame_tick = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (tcount >= tick_period - 1) begin
                bus.frame_tick = 1'b1;
                tcount = 0;
            end else begin
                bus.frame_tick = 1'b0;
                tcount++;
            end
        end
    end

    // Reference model: key accepted after DB consecutive equal samples seen two clocks late;
    // hops tracked as remaining-tick budgets.
    logic [3:0] m_d1, m_d2, m_run_val, m_stable, m_stable_prev;
    int         m_run_len [4];
    bit         m_pend;
    int         m_pdir;
    int         m_phase;
    int         m_left;
    int         m_dir;
    logic [3:0] e_dirs;
    logic       e_active, e_done;
    logic [7:0] m_up;

    function automatic int first_dir(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge CLK or negedge RESETn) begin
        logic [3:0] raw, press, levels;
        bit go_idle;
        if (!RESETn) begin
            m_d1 = 0; m_d2 = 0; m_run_val = 0; m_stable = 0; m_stable_prev = 0;
            for (int k = 0; k < 4; k++) m_run_len[k] = 0;
            m_pend = 0; m_pdir = 0; m_phase = 0; m_left = 0; m_dir = 0;
            e_dirs = 0; e_active = 0; e_done = 0; m_up = 0;
        end else begin
            raw    = {bus.key_right, bus.key_left, bus.key_down, bus.key_up};
            press  = m_stable & ~m_stable_prev;
            levels = m_stable;
            for (int k = 0; k < 4; k++) begin
                if (m_d2[k] == m_run_val[k]) m_run_len[k]++;
                else begin m_run_val[k] = m_d2[k]; m_run_len[k] = 1; end
                if (m_run_len[k] >= DB && m_run_val[k] != m_stable[k]) m_stable[k] = m_run_val[k];
            end
            m_stable_prev = levels;
            m_d2 = m_d1;
            m_d1 = raw;
            e_done  = 0;
            go_idle = 0;
            if (bus.freeze) begin
                m_phase = 0;
                m_pend  = 0;
            end else if (m_phase == 0) begin
                if (bus.frame_tick && m_pend) begin
                    m_phase = 1; m_left = HF; m_dir = m_pdir; m_pend = 0;
                end else if (press != 0 && !m_pend) begin
                    m_pend = 1; m_pdir = first_dir(press);
                end
            end else if (m_phase == 1) begin
                if (bus.frame_tick) begin
                    m_left--;
                    if (m_left == 0) begin
                        e_done = 1;
                        if (m_dir == 0 && m_up < 255) m_up++;
                        if (CF == 0) go_idle = 1;
                        else begin m_phase = 2; m_left = CF; end
                    end
                end
            end else if (bus.frame_tick) begin
                m_left--;
                if (m_left == 0) go_idle = 1;
            end
            if (go_idle) begin
                m_phase = 0;
`ifdef FROG_AUTOREPEAT_EN
                if (levels != 0) begin m_pend = 1; m_pdir = first_dir(levels); end
`endif
            end
            e_dirs   = (m_phase == 1) ? (4'b0001 << m_dir) : 4'b0000;
            e_active = (m_phase == 1);
        end
    end

    logic [13:0] obs, expv;
    assign obs  = {bus.right, bus.left, bus.down, bus.up, bus.hop_active, bus.hop_done, bus.up_hops};
    assign expv = {e_dirs, e_active, e_done, m_up};

    task automatic test_reset();
        RESETn = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            n_checks++;
            if (obs !== 14'd0) $display("FAIL reset_state: got %h expected %h", obs, 14'd0);
            else n_pass++;
        end
        @(posedge CLK); #1;
        RESETn = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (obs !== expv) $display("FAIL reset_release: got %h expected %h", obs, expv);
        else n_pass++;
    endtask

    task automatic test_single_up();
        int up_ticks, dones;
        up_ticks = 0; dones = 0;
        for (int c = 0; c < 850; c++) begin
            @(posedge CLK); #1;
            bus.key_up = (c < 100);
            @(negedge CLK);
            n_checks++;
            if (obs !== expv) $display("FAIL single_up c=%0d: got %h expected %h", c, obs, expv);
            else n_pass++;
            if (bus.frame_tick && bus.up) up_ticks++;
            if (bus.hop_done) dones++;
        end
        n_checks++;
        if (up_ticks !== HF) $display("FAIL single_up_ticks: got %0d expected %0d", up_ticks, HF);
        else n_pass++;
        n_checks++;
        if (dones !== 1) $display("FAIL single_up_done: got %0d expected 1", dones);
        else n_pass++;
        n_checks++;
        if (bus.up_hops !== 8'd1) $display("FAIL single_up_count: got %0d expected 1", bus.up_hops);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int left_seen;
        left_seen = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge CLK); #1;
            bus.key_left = (c < 200) ? 1'(((c / 5) % 2) == 0) : 1'b0;
            @(negedge CLK);
            n_checks++;
            if (obs !== expv) $display("FAIL bounce c=%0d: got %h expected %h", c, obs, expv);
            else n_pass++;
            if (bus.left || bus.hop_active) left_seen++;
        end
        n_checks++;
        if (left_seen !== 0) $display("FAIL bounce_left: got %0d active cycles expected 0", left_seen);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int right_seen, up_ticks;
        right_seen = 0; up_ticks = 0;
        for (int c = 0; c < 850; c++) begin
            @(posedge CLK); #1;
            bus.key_up    = (c < 100);
            bus.key_right = (c < 100);
            @(negedge CLK);
            n_checks++;
            if (obs !== expv) $display("FAIL simultaneous c=%0d: got %h expected %h", c, obs, expv);
            else n_pass++;
            if (bus.right) right_seen++;
            if (bus.frame_tick && bus.up) up_ticks++;
        end
        n_checks++;
        if (right_seen !== 0) $display("FAIL simultaneous_right: got %0d expected 0", right_seen);
        else n_pass++;
        n_checks++;
        if (up_ticks !== HF) $display("FAIL simultaneous_up: got %0d expected %0d", up_ticks, HF);
        else n_pass++;
    endtask

    task automatic test_hold();
        int dones;
        dones = 0;
        for (int c = 0; c < 2700; c++) begin
            @(posedge CLK); #1;
            bus.key_down = (c < 40 * 50);
            @(negedge CLK);
            n_checks++;
            if (obs !== expv) $display("FAIL hold c=%0d: got %h expected %h", c, obs, expv);
            else n_pass++;
            if (bus.hop_done) dones++;
        end
        n_checks++;
`ifdef FROG_AUTOREPEAT_EN
        if (dones < 3) $display("FAIL hold_repeat: got %0d hops expected at least 3", dones);
        else n_pass++;
`else
        if (dones !== 1) $display("FAIL hold_single: got %0d hops expected 1", dones);
        else n_pass++;
`endif
    endtask

    task automatic test_freeze();
        int seen, budget, down_ticks;
        logic [7:0] saved_up;
        seen = 0; budget = 0; down_ticks = 0;
        while (seen < 3 && budget < 1000) begin
            @(posedge CLK); #1;
            bus.key_up = (budget < 100);
            if (bus.hop_active && bus.frame_tick) seen++;
            if (seen == 3) bus.freeze = 1'b1;
            @(negedge CLK);
            n_checks++;
            if (obs !== expv) $display("FAIL freeze_wait c=%0d: got %h expected %h", budget, obs, expv);
            else n_pass++;
            budget++;
        end
        n_checks++;
        if (seen !== 3) $display("FAIL freeze_timeout: got %0d hop ticks expected 3", seen);
        else n_pass++;
        saved_up = m_up;
        @(posedge CLK); #1;
        bus.freeze = 1'b0;
        bus.key_up = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (obs[13:8] !== 6'd0) $display("FAIL freeze_outputs: got %h expected 0", obs[13:8]);
        else n_pass++;
        n_checks++;
        if (bus.up_hops !== saved_up) $display("FAIL freeze_count: got %0d expected %0d", bus.up_hops, saved_up);
        else n_pass++;
        for (int c = 0; c < 850; c++) begin
            @(posedge CLK); #1;
            bus.key_down = (c < 100);
            @(negedge CLK);
            n_checks++;
            if (obs !== expv) $display("FAIL freeze_after c=%0d: got %h expected %h", c, obs, expv);
            else n_pass++;
            if (bus.frame_tick && bus.down) down_ticks++;
        end
        n_checks++;
        if (down_ticks !== HF) $display("FAIL freeze_relaunch: got %0d expected %0d", down_ticks, HF);
        else n_pass++;
    endtask

    task automatic test_reset_mid_hop();
        int budget;
        budget = 0;
        while (!bus.hop_active && budget < 400) begin
            @(posedge CLK); #1;
            bus.key_up = (budget < 60);
            @(negedge CLK);
            n_checks++;
            if (obs !== expv) $display("FAIL rst_mid_wait c=%0d: got %h expected %h", budget, obs, expv);
            else n_pass++;
            budget++;
        end
        n_checks++;
        if (!bus.hop_active) $display("FAIL rst_mid_timeout: got hop_active 0 expected 1");
        else n_pass++;
        bus.key_up = 1'b0;
        repeat (120) @(posedge CLK);
        #2;
        RESETn = 1'b0;
        #1;
        n_checks++;
        if (obs !== 14'd0) $display("FAIL rst_mid_async: got %h expected %h", obs, 14'd0);
        else n_pass++;
        repeat (3) begin
            @(negedge CLK);
            n_checks++;
            if (obs !== 14'd0) $display("FAIL rst_mid_hold: got %h expected %h", obs, 14'd0);
            else n_pass++;
        end
        @(posedge CLK); #1;
        RESETn = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (bus.up_hops !== 8'd0) $display("FAIL rst_mid_count: got %0d expected 0", bus.up_hops);
        else n_pass++;
    endtask

    task automatic test_random();
        int seg;
        seg = 0;
        tick_period = 12;
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK); #1;
            if (seg == 0) begin
                {bus.key_right, bus.key_left, bus.key_down, bus.key_up} = 4'($urandom_range(0, 15));
                seg = $urandom_range(1, 40);
            end
            seg--;
            bus.freeze = ($urandom_range(0, 149) == 0);
            @(negedge CLK);
            n_checks++;
            if (obs !== expv) $display("FAIL random c=%0d: got %h expected %h", c, obs, expv);
            else n_pass++;
        end
        bus.freeze = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        tick_period = 50;
        RESETn = 1'b0;
        bus.freeze = 1'b0;
        bus.key_left = 1'b0;
        bus.key_right = 1'b0;
        bus.key_up = 1'b0;
        bus.key_down = 1'b0;
        test_reset();
        test_single_up();
        test_bounce();
        test_simultaneous();
        test_hold();
        test_freeze();
        test_reset_mid_hop();
        test_random();
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
